digit_argmax: RTL
=================

Name: digit_argmax

Overview:
- Upstream stage of the single-digit seven-segment display driver.
- Consumes the per-class score stream from the digit recognition engine, one signed score per beat, classes 0..NUM_CLASS-1 in order.
- Selects the class with the highest score and holds it on a 4-bit num output until the next valid frame. The display driver decodes num directly.
- Drives BLANK_CODE (decoded as all segments off) after reset and after any malformed frame.

Parameters:
- SCORE_W, 16: width of each signed two's-complement score.
- NUM_CLASS, 10: scores per frame; legal range 2..10.
- BLANK_CODE, 4'hF: num value that blanks the display.

Ports:
- sys_clk  input  1  system clock; all logic is on the rising edge.
- sys_rst  input  1  asynchronous active-high reset.
- frame_start  input  1  one-cycle pulse; aborts any partial frame and restarts the class index at 0.
- score_valid  input  1  score_data holds a valid score this cycle; gaps between beats are allowed.
- score_data  input  SCORE_W  signed class score.
- score_last  input  1  final beat of the frame; qualified by score_valid.
- num  output  4  held result class, or BLANK_CODE.
- num_valid  output  1  one-cycle pulse when num is updated with a good result.
- busy  output  1  high while a frame is partially received.
- err  output  1  one-cycle pulse when a malformed frame is detected.

Behaviour:
- Reset values: num=BLANK_CODE, num_valid=0, busy=0, err=0, state IDLE, idx=0, best_idx=0, best_score=most-negative value.
- There is no backpressure. Every score_valid beat is consumed. score_last without score_valid is ignored.
- States:
  - IDLE: wait for data. On a score_valid beat, load best_score=score_data, best_idx=0, idx=1. Go to ACC, or to DONE/ERR if score_last is also set.
  - ACC: on each valid beat, compare score_data against best_score.
    - Strictly-greater replaces best, so ties go to the lower index.
    - idx increments per beat.
  - DONE: one cycle. num<=best_idx, num_valid=1, then return to IDLE.
  - ERR: one cycle. num<=BLANK_CODE, err=1, then return to IDLE.
- Comparison is signed over the full SCORE_W with no saturation. Internal registers: idx and best_idx are 4 bits; best_score is SCORE_W bits.
- Latency: num and num_valid change in the cycle after the score_last beat.
- Frame checks:
  - score_last on beat number NUM_CLASS (idx==NUM_CLASS-1 at that beat) goes to DONE.
  - score_last on any earlier beat goes to ERR (short frame).
  - A valid beat without score_last when idx==NUM_CLASS-1 goes to ERR (long frame). Further beats until the next score_last are ignored; the state stays in IDLE with a drop flag set, and the flag clears on score_last or frame_start.
- busy=1 in ACC; busy=0 in IDLE, DONE and ERR.
- frame_start in any state: discard the partial result, clear the drop flag, and go to IDLE. num is unchanged.
  - If score_valid is set in the same cycle, that beat is treated as index 0 of the new frame.
  - frame_start in DONE or ERR still completes that cycle's output, then restarts.
- num holds its last value indefinitely between frames.
- Reset asserted mid-frame immediately returns all outputs to their reset values.

Decomposition:
- Shared package digit_pkg:
  - SCORE_W, NUM_CLASS, BLANK_CODE.
  - State enum {IDLE, ACC, DONE, ERR}.
  - score_t typedef (signed [SCORE_W-1:0]).
- The display driver uses BLANK_CODE from the same package.
- One natural sub-module, argmax_cmp: combinational signed strictly-greater compare-and-select of (best_score, best_idx) against (score_data, idx).
- The FSM, counters and output registers stay in digit_argmax.

Test Plan:
- Reset then idle -> num=4'hF, num_valid=0, err=0, busy=0.
- Frame 10 beats, scores {5,-3,100,7,0,99,12,1200,-50,1199}, last on beat 10 -> next cycle num=7, one-cycle num_valid; busy high on beats 2-10.
- Tie frame with index 2 and index 6 both 500, rest 0 -> num=2. All-negative frame {-9,-2,-7,...,-100} -> num=1.
- Short frame, score_last on beat 6 -> err pulse, num=4'hF, no num_valid. Next good frame with max at index 4 -> num=4.
- Long frame, 12 beats, last on beat 12 -> one err pulse after beat 10, beats 11-12 ignored, num=4'hF.
- frame_start after 4 beats (prior num=3), then a full frame with max at index 9 and gaps of 0-3 idle cycles between beats -> num stays 3 until the end of the frame, then num=9. sys_rst asserted mid-frame -> num=4'hF immediately.

Source files
------------

// File: rtl/digit_pkg.sv
// digit_pkg: shared definitions for the digit recognition back end.
// Holds the score format, frame size and blank code, used by digit_argmax
// and by the seven-segment display driver that decodes num.
package digit_pkg;

  localparam int SCORE_W   = 16;
  localparam int NUM_CLASS = 10;  // legal range 2..10
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/digit_argmax_cmp.sv
// argmax_cmp: combinational compare-and-select for the running argmax.
// Ports:
//   best_score / best_idx : current champion
//   cand_score / cand_idx : incoming beat
//   sel_score  / sel_idx  : winner (candidate only if strictly greater,
//                           so ties keep the earlier, lower index)
//   take                  : candidate replaced the champion
module argmax_cmp
  import digit_pkg::*;
(
  input  logic signed [SCORE_W-1:0] best_score,
  input  logic        [3:0]         best_idx,
  input  logic signed [SCORE_W-1:0] cand_score,
  input  logic        [3:0]         cand_idx,
  output logic signed [SCORE_W-1:0] sel_score,
  output logic        [3:0]         sel_idx,
  output logic                      take
);

  always_comb begin
    take      = (cand_score > best_score);
    sel_score = take ? cand_score : best_score;
    sel_idx   = take ? cand_idx   : best_idx;
  end

endmodule

// File: rtl/digit_argmax.sv
// digit_argmax: picks the highest-scoring class of a score frame and holds it
// on num for the seven-segment display driver.
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   frame_start      : aborts any partial frame, next beat is class 0
//   score_valid      : score_data/score_last are valid this cycle
//   score_data       : signed class score, classes arrive in order
//   score_last       : final beat of the frame (qualified by score_valid)
//   num              : held winning class, or BLANK_CODE
//   num_valid        : one-cycle pulse when num takes a good result
//   busy             : a frame is partially received
//   err              : one-cycle pulse on a short or long frame
module digit_argmax
  import digit_pkg::*;
(
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      frame_start,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score_data,
  input  logic                      score_last,
  output logic        [3:0]         num,
  output logic                      num_valid,
  output logic                      busy,
  output logic                      err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASS - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  best_idx_q, best_idx_d;
  score_t      best_score_q, best_score_d;
  logic [3:0]  num_q, num_d;
  logic        drop_q, drop_d;

  score_t      sel_score;
  logic [3:0]  sel_idx;
  logic        take;

  logic        in_acc;
  logic        drop_eff;

  argmax_cmp u_cmp (
    .best_score (best_score_q),
    .best_idx   (best_idx_q),
    .cand_score (score_data),
    .cand_idx   (idx_q),
    .sel_score  (sel_score),
    .sel_idx    (sel_idx),
    .take       (take)
  );

  always_comb begin
    // frame_start overrides the current state for beat handling: the beat in
    // the same cycle (if any) becomes index 0 of a fresh frame.
    in_acc   = (state_q == ACC) && !frame_start;
    drop_eff = drop_q && !frame_start;

    state_d      = in_acc ? ACC : IDLE;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    num_d        = num_q;
    drop_d       = drop_eff;

    if (frame_start) begin
      idx_d        = 4'd0;
      best_idx_d   = 4'd0;
      best_score_d = SCORE_MIN;
    end

    if (score_valid) begin
      if (in_acc) begin
        if (score_last) begin
          // num is loaded on the last beat so it moves together with the
          // num_valid/err pulse in the following cycle.
          state_d      = (idx_q == LAST_IDX) ? DONE : ERR;
          num_d        = (idx_q == LAST_IDX) ? sel_idx : BLANK_CODE;
          idx_d        = 4'd0;
          best_idx_d   = 4'd0;
          best_score_d = SCORE_MIN;
        end else if (idx_q == LAST_IDX) begin
          // Long frame: swallow the surplus beats up to the next score_last.
          state_d      = ERR;
          num_d        = BLANK_CODE;
          drop_d       = 1'b1;
          idx_d        = 4'd0;
          best_idx_d   = 4'd0;
          best_score_d = SCORE_MIN;
        end else begin
          best_score_d = sel_score;
          best_idx_d   = sel_idx;
          idx_d        = idx_q + 4'd1;
        end
      end else if (drop_eff) begin
        if (score_last) begin
          drop_d = 1'b0;
        end
      end else begin
        // First beat of a frame (IDLE, or the beat overlapping DONE/ERR).
        best_score_d = score_data;
        best_idx_d   = 4'd0;
        idx_d        = 4'd1;
        if (score_last) begin
          // A one-beat frame is always short since NUM_CLASS >= 2.
          state_d = ERR;
          num_d   = BLANK_CODE;
          idx_d   = 4'd0;
        end else begin
          state_d = ACC;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      best_idx_q   <= 4'd0;
      best_score_q <= SCORE_MIN;
      num_q        <= BLANK_CODE;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      num_q        <= num_d;
      drop_q       <= drop_d;
    end
  end

  assign num       = num_q;
  assign num_valid = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign busy      = (state_q == ACC);

endmodule
